// File: rtl/rv32_instr_encoder.sv
// RV32I instruction encoder: two-stage valid/ready pipeline that
// assembles R/I/S/B/U/J words from decoded fields, flags malformed ones.
// Ports: in_* field bundle with in_valid/in_ready handshake;
//        out_instr/out_fmt/out_err with out_valid/out_ready handshake;
//        err_sticky (first emitted error), out_count (emits, wraps).
// Optional: define ENC_RANGE_CHECK_EN to flag out-of-range immediates.
module rv32_instr_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_fmt,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [2:0]       out_fmt,
   output logic             out_err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] out_count
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } fields_t;

   fields_t     s1;
   logic        s1_valid;
   logic        s2_valid;
   logic        s2_load;
   logic        emit;
   logic [31:0] enc_word;
   logic        enc_err;
   logic        fmt_bad;
   logic        align_bad;
   logic        range_bad;
   logic        is_r, is_i, is_s, is_b, is_u, is_j;

   assign s2_load   = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s2_load;
   assign out_valid = s2_valid;
   assign emit      = s2_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1.fmt    <= in_fmt;
            s1.opcode <= in_opcode;
            s1.rd     <= in_rd;
            s1.rs1    <= in_rs1;
            s1.rs2    <= in_rs2;
            s1.funct3 <= in_funct3;
            s1.funct7 <= in_funct7;
            s1.imm    <= in_imm;
         end
      end
   end

   assign is_r = (s1.fmt == FMT_R);
   assign is_i = (s1.fmt == FMT_I);
   assign is_s = (s1.fmt == FMT_S);
   assign is_b = (s1.fmt == FMT_B);
   assign is_u = (s1.fmt == FMT_U);
   assign is_j = (s1.fmt == FMT_J);

   always_comb begin
      enc_word  = 32'h0;
      fmt_bad   = 1'b0;
      align_bad = 1'b0;
      unique case (1'b1)
         is_r: enc_word = {s1.funct7, s1.rs2, s1.rs1,
                           s1.funct3, s1.rd, s1.opcode};
         is_i: enc_word = {s1.imm[11:0], s1.rs1,
                           s1.funct3, s1.rd, s1.opcode};
         is_s: enc_word = {s1.imm[11:5], s1.rs2, s1.rs1,
                           s1.funct3, s1.imm[4:0], s1.opcode};
         is_b: begin
            enc_word  = {s1.imm[12], s1.imm[10:5], s1.rs2,
                         s1.rs1, s1.funct3, s1.imm[4:1],
                         s1.imm[11], s1.opcode};
            align_bad = s1.imm[0];
         end
         is_u: enc_word = {s1.imm[31:12], s1.rd, s1.opcode};
         is_j: begin
            enc_word  = {s1.imm[20], s1.imm[10:1], s1.imm[11],
                         s1.imm[19:12], s1.rd, s1.opcode};
            align_bad = s1.imm[0];
         end
         default: fmt_bad = 1'b1;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   // A signed value fits N bits when all bits above N-1 match the sign.
   logic fits_12, fits_13, fits_21;
   assign fits_12 = (&s1.imm[31:11]) || !(|s1.imm[31:11]);
   assign fits_13 = (&s1.imm[31:12]) || !(|s1.imm[31:12]);
   assign fits_21 = (&s1.imm[31:20]) || !(|s1.imm[31:20]);

   always_comb begin
      range_bad = 1'b0;
      unique case (1'b1)
         is_i, is_s: range_bad = !fits_12;
         is_b:       range_bad = !fits_13;
         is_j:       range_bad = !fits_21;
         is_u:       range_bad = |s1.imm[11:0];
         default:    range_bad = 1'b0;
      endcase
   end
`else
   assign range_bad = 1'b0;
`endif

   assign enc_err = fmt_bad || align_bad || range_bad ||
                    (s1.opcode[1:0] != 2'b11);

   // Payload only moves with a real bundle so a stalled or
   // draining output keeps its last word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         out_instr <= 32'h0;
         out_fmt   <= 3'd0;
         out_err   <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_instr <= enc_word;
            out_fmt   <= s1.fmt;
            out_err   <= enc_err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
         out_count  <= '0;
      end else if (emit) begin
         out_count <= out_count + 1'b1;
         if (out_err) err_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Scoreboard bench for rv32_instr_encoder.
// Directed stimulus; negedge monitor pops expected words.
module tb_rv32_instr_encoder;

   localparam int CNT_W = 16;

`ifdef ENC_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_fmt;
   logic [6:0]       in_opcode;
   logic [4:0]       in_rd;
   logic [4:0]       in_rs1;
   logic [4:0]       in_rs2;
   logic [2:0]       in_funct3;
   logic [6:0]       in_funct7;
   logic [31:0]      in_imm;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic [2:0]       out_fmt;
   logic             out_err;
   logic             err_sticky;
   logic [CNT_W-1:0] out_count;

   rv32_instr_encoder #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_fmt(out_fmt),
      .out_err(out_err), .err_sticky(err_sticky),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  fmt;
      logic        err;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   n_emit = 0;
   logic sticky_m = 1'b0;
   int   cyc = 0;
   int   emit_cyc[0:63];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (q.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("instr", out_instr, mon_e.instr);
            chk("fmt", 32'(out_fmt), 32'(mon_e.fmt));
            chk("err", 32'(out_err), 32'(mon_e.err));
            chk("count", 32'(out_count), 32'(n_emit[CNT_W-1:0]));
            chk("sticky", 32'(err_sticky), 32'(sticky_m));
            sticky_m = sticky_m | mon_e.err;
         end
         if (n_emit < 64) emit_cyc[n_emit] = cyc;
         n_emit++;
      end
   end

   task automatic set_fields(input logic [2:0] f, input logic [6:0] op,
                             input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] imm);
      in_valid  = 1'b1;
      in_fmt    = f;
      in_opcode = op;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_funct3 = f3;
      in_funct7 = f7;
      in_imm    = imm;
   endtask

   // Called #1 after a posedge; returns #1 after the accepting edge.
   task automatic send(input logic [2:0] f, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       input logic [31:0] ei, input logic ee);
      logic acc;
      int   n;
      exp_t e;
      n = 0;
      set_fields(f, op, rd, rs1, rs2, f3, f7, imm);
      forever begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         if (acc === 1'b1) break;
         n++;
         if (n > 50) break;
      end
      checks++;
      assert (acc === 1'b1) else begin
         errors++;
         $error("FAIL accept_timeout: in_ready %b required 1", acc);
      end
      if (acc === 1'b1) begin
         e.instr = ei;
         e.fmt   = f;
         e.err   = ee;
         q.push_back(e);
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   int base;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      in_valid  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_fmt", 32'(out_fmt), 32'd0);
      chk("rst_err", 32'(out_err), 32'd0);
      chk("rst_sticky", 32'(err_sticky), 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // add x3,x1,x2 with latency probe
      send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,
           32'h002081B3, 1'b0);
      @(negedge clk);
      chk("lat_n1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_n2_valid", 32'(out_valid), 32'd1);
      chk("lat_n2_instr", out_instr, 32'h002081B3);
      drain();
      chk("count_after_add", 32'(out_count), 32'd1);
      chk("idle_valid", 32'(out_valid), 32'd0);

      // addi x1,x0,-1 ; beq x1,x2,+8 ; jal x1,+2048
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF,
           32'hFFF00093, 1'b0);
      send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,
           32'h00208463, 1'b0);
      send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800,
           32'h001000EF, 1'b0);
      drain();

      // four back-to-back: sw, lui, beq -4, jal -8
      base = n_emit;
      send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12,
           32'h0020A623, 1'b0);
      send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,
           32'h123452B7, 1'b0);
      send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC,
           32'hFE000EE3, 1'b0);
      send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFF8,
           32'hFF9FF06F, 1'b0);
      drain();
      chk("b2b_span", 32'(emit_cyc[base+3] - emit_cyc[base]), 32'd3);

      // backpressure: two accepts then stall
      out_ready = 1'b0;
      send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,
           32'h002081B3, 1'b0);
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF,
           32'hFFF00093, 1'b0);
      set_fields(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'h12345000);
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_hold", out_instr, 32'h002081B3);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,
           32'h123452B7, 1'b0);
      drain();
      chk("bp_count", 32'(out_count), 32'(n_emit));
      chk("pre_err_sticky", 32'(err_sticky), 32'd0);

      // errors
      send(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h1234,
           32'h00000000, 1'b1);
      drain();
      chk("fmt6_sticky", 32'(err_sticky), 32'd1);
      send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7,
           32'h00000363, 1'b1);
      send(3'd0, 7'h30, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,
           32'h00000030, 1'b1);
      send(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,
           32'h80000013, RC);
      drain();

      // reset with both stages full
      out_ready = 1'b0;
      send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,
           32'h002081B3, 1'b0);
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF,
           32'hFFF00093, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_count", 32'(out_count), 32'd0);
      chk("mid_rst_sticky", 32'(err_sticky), 32'd0);
      chk("mid_rst_instr", out_instr, 32'd0);
      q.delete();
      n_emit   = 0;
      sticky_m = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800,
           32'h001000EF, 1'b0);
      drain();
      chk("post_rst_count", 32'(out_count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
